vga_sync_decoder: RTL

- Receive-side counterpart of the 640x480 VGA timing generator. Consumes HSYNC/VSYNC and 4-bit RGB, either looped back on-chip or driven by a bench.
- Locks onto the raster, recovers pixel coordinates and streams active pixels out.
- Produces a per-frame 16-bit pixel checksum for self-test of the sprite/palette drawing path.
- Sits beside the top-level display logic and shares its 100 MHz clock.

---
 rtl/vga_sync_decoder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA raster decoder: locks to HSYNC/VSYNC rise positions, recovers pixel
// coordinates, streams active pixels and produces a per-frame 16-bit rgb checksum.
module vga_sync_decoder #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_pix_stb,
   input  logic        i_hsync,
   input  logic        i_vsync,
   input  logic [3:0]  i_red,
   input  logic [3:0]  i_green,
   input  logic [3:0]  i_blue,
   output logic [9:0]  o_x,
   output logic [9:0]  o_y,
   output logic [11:0] o_rgb,
   output logic        o_valid,
   output logic        o_locked,
   output logic        o_sync_err,
   output logic        o_frame_done,
   output logic [15:0] o_frame_sum,
   output logic [7:0]  o_frame_cnt
);

   localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_RISE  = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_RISE  = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] H_VIS   = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS   = 10'(V_ACTIVE);

   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_CHECK  = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   logic [1:0]  state_r;
   logic [9:0]  h_r;
   logic [9:0]  v_r;
   logic        hs_prev_r;
   logic        vs_prev_r;
   logic        bad_r;
   logic [15:0] acc_r;

   logic        hs_rise_s;
   logic        vs_rise_s;
   logic        h_ok_s;
   logic        vh_ok_s;
   logic        hs_bad_s;
   logic        lock_err_s;
   logic        pix_s;
   logic [11:0] rgb_s;
   logic [15:0] sum_add_s;
   logic [9:0]  cur_h_s;
   logic [9:0]  cur_v_s;
   logic [9:0]  h_nx_s;
   logic [9:0]  v_nx_s;
   logic [1:0]  state_nx_s;
   logic        bad_nx_s;

   // Edge detection, realignment of the current sample's coordinate and next-state logic.
   always_comb begin
      hs_rise_s  = i_hsync & ~hs_prev_r;
      vs_rise_s  = i_vsync & ~vs_prev_r;
      h_ok_s     = (h_r == H_RISE);
      vh_ok_s    = (v_r == V_RISE) && (h_r == 10'd0);
      hs_bad_s   = hs_rise_s && !h_ok_s;
      lock_err_s = (state_r == ST_LOCKED) &&
                   ((hs_rise_s && !h_ok_s) || (vs_rise_s && !vh_ok_s));
      cur_h_s    = h_r;
      cur_v_s    = v_r;
      state_nx_s = state_r;
      bad_nx_s   = bad_r;
      case (state_r)
         ST_SEARCH: begin
            if (vs_rise_s) begin
               cur_h_s    = 10'd0;
               cur_v_s    = V_RISE;
               bad_nx_s   = 1'b0;
               state_nx_s = ST_CHECK;
            end else if (hs_rise_s) begin
               cur_h_s = H_RISE;
            end else begin
               cur_h_s = h_r;
            end
         end
         ST_CHECK: begin
            if (hs_bad_s) begin
               cur_h_s = H_RISE;
            end else begin
               cur_h_s = h_r;
            end
            // A misplaced hsync in the same sample as the vsync rise still blocks lock.
            if (vs_rise_s) begin
               bad_nx_s = 1'b0;
               if (!bad_r && !hs_bad_s && vh_ok_s) begin
                  state_nx_s = ST_LOCKED;
               end else begin
                  cur_h_s = 10'd0;
                  cur_v_s = V_RISE;
               end
            end else if (hs_bad_s) begin
               bad_nx_s = 1'b1;
            end else begin
               bad_nx_s = bad_r;
            end
         end
         ST_LOCKED: begin
            if (lock_err_s) begin
               state_nx_s = ST_SEARCH;
            end else begin
               state_nx_s = ST_LOCKED;
            end
         end
         default: begin
            state_nx_s = ST_SEARCH;
         end
      endcase

      if (cur_h_s == H_LAST) begin
         h_nx_s = 10'd0;
         if (cur_v_s == V_LAST) begin
            v_nx_s = 10'd0;
         end else begin
            v_nx_s = cur_v_s + 10'd1;
         end
      end else begin
         h_nx_s = cur_h_s + 10'd1;
         v_nx_s = cur_v_s;
      end

      rgb_s = {i_red, i_green, i_blue};
      pix_s = (state_r == ST_LOCKED) && !lock_err_s && (h_r < H_VIS) && (v_r < V_VIS);
      if (pix_s) begin
         sum_add_s = acc_r + {4'd0, rgb_s};
      end else begin
         sum_add_s = acc_r;
      end
   end

   // Raster tracking state, pixel output registers and frame checksum.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_r      <= ST_SEARCH;
         h_r          <= 10'd0;
         v_r          <= 10'd0;
         hs_prev_r    <= 1'b0;
         vs_prev_r    <= 1'b0;
         bad_r        <= 1'b0;
         acc_r        <= 16'd0;
         o_x          <= 10'd0;
         o_y          <= 10'd0;
         o_rgb        <= 12'd0;
         o_valid      <= 1'b0;
         o_locked     <= 1'b0;
         o_sync_err   <= 1'b0;
         o_frame_done <= 1'b0;
         o_frame_sum  <= 16'd0;
         o_frame_cnt  <= 8'd0;
      end else begin
         o_valid      <= 1'b0;
         o_sync_err   <= 1'b0;
         o_frame_done <= 1'b0;
         if (i_pix_stb) begin
            state_r   <= state_nx_s;
            h_r       <= h_nx_s;
            v_r       <= v_nx_s;
            bad_r     <= bad_nx_s;
            hs_prev_r <= i_hsync;
            vs_prev_r <= i_vsync;
            o_locked  <= (state_nx_s == ST_LOCKED);
            o_sync_err <= lock_err_s;
            if (pix_s) begin
               o_x     <= h_r;
               o_y     <= v_r;
               o_rgb   <= rgb_s;
               o_valid <= 1'b1;
            end
            if (vs_rise_s) begin
               acc_r <= 16'd0;
               if ((state_r == ST_LOCKED) && !lock_err_s) begin
                  o_frame_sum  <= sum_add_s;
                  o_frame_done <= 1'b1;
                  o_frame_cnt  <= o_frame_cnt + 8'd1;
               end
            end else begin
               acc_r <= sum_add_s;
            end
         end
      end
   end

endmodule
